// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: values shared by the change dispenser and the sale controller.
// Holds the default amount/inventory widths, coin values in nickel units and
// the dispenser FSM state encoding.
package change_dispenser_pkg;

  localparam int AMT_W_DEF   = 4;
  localparam int CNT_W_DEF   = 6;
  localparam int TIMEOUT_DEF = 255;

  // Coin values expressed in nickel units.
  localparam int unsigned NICKEL = 1;
  localparam int unsigned DIME   = 2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_EJECT   = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_FAULT   = 3'd5;

  // Busy covers every state that is working a transaction.
  function automatic logic is_busy_state(input logic [2:0] st);
    return (st == ST_SELECT) || (st == ST_EJECT) ||
           (st == ST_RELEASE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/change_dispenser_handshake_timer.sv
// change_dispenser_handshake_timer: clearable wait counter with a terminal-count flag.
// Ports: i_clk/i_reset (async active-high), i_clr restarts the count,
// i_en advances it, o_tc is high once TIMEOUT cycles have been counted.
module change_dispenser_handshake_timer
  import change_dispenser_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // The cycle in which the count reads TIMEOUT-1 is the TIMEOUT-th waiting
  // cycle, so a wait that is still unanswered there has used its full budget.
  assign o_tc = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change as dime/nickel eject requests over a 4-phase
// req/ack handshake with the coin-return mechanism, tracking coin inventory.
// Ports: start/amount and load/load_n/load_d sampled in IDLE; coin_ack from the
// mechanism; eject_n/eject_d requests; busy/done/short/fault status; remaining,
// nickels and dimes expose the unpaid amount and inventory. All outputs registered.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int AMT_W   = AMT_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             load,
  input  logic [CNT_W-1:0] load_n,
  input  logic [CNT_W-1:0] load_d,
  input  logic             coin_ack,
  output logic             eject_n,
  output logic             eject_d,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] nickels,
  output logic [CNT_W-1:0] dimes
);

  logic [2:0]       r_state;
  logic             r_eject_n;
  logic             r_eject_d;
  logic             r_busy;
  logic             r_done;
  logic             r_short;
  logic             r_fault;
  logic [AMT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_nickels;
  logic [CNT_W-1:0] r_dimes;

  logic [2:0] w_next;
  logic       w_tc;
  logic       w_clr;
  logic       w_sel_d;
  logic       w_sel_n;
  logic       w_short_sel;
  logic       w_coin_taken;
  logic       w_timer_en;

  assign w_timer_en = (r_state == ST_EJECT) || (r_state == ST_RELEASE);

  change_dispenser_handshake_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_clr),
    .i_en    (w_timer_en),
    .o_tc    (w_tc)
  );

  always_comb begin
    w_next       = r_state;
    w_clr        = 1'b0;
    w_sel_d      = 1'b0;
    w_sel_n      = 1'b0;
    w_short_sel  = 1'b0;
    w_coin_taken = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A simultaneous load takes precedence and the start is dropped.
        if (start && !load) w_next = ST_SELECT;
      end
      ST_SELECT: begin
        // Largest coin first; never pay a dime against a single nickel owed.
        if ((r_remaining >= AMT_W'(DIME)) && (r_dimes != '0)) begin
          w_next  = ST_EJECT;
          w_sel_d = 1'b1;
          w_clr   = 1'b1;
        end else if ((r_remaining >= AMT_W'(NICKEL)) && (r_nickels != '0)) begin
          w_next  = ST_EJECT;
          w_sel_n = 1'b1;
          w_clr   = 1'b1;
        end else begin
          w_next      = ST_DONE;
          w_short_sel = (r_remaining != '0);
        end
      end
      ST_EJECT: begin
        if (coin_ack) begin
          w_next       = ST_RELEASE;
          w_clr        = 1'b1;
          w_coin_taken = 1'b1;
        end else if (w_tc) begin
          w_next = ST_FAULT;
        end
      end
      ST_RELEASE: begin
        if (!coin_ack) begin
          w_next = ST_SELECT;
        end else if (w_tc) begin
          w_next = ST_FAULT;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_FAULT: w_next = ST_FAULT;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_eject_n   <= 1'b0;
      r_eject_d   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_fault     <= 1'b0;
      r_remaining <= '0;
      r_nickels   <= '0;
      r_dimes     <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= is_busy_state(w_next);
      r_done  <= (w_next == ST_DONE);
      r_fault <= (w_next == ST_FAULT);

      // Requests rise on leaving SELECT and fall on any exit from EJECT
      // (coin released or handshake timeout).
      if (w_sel_d) begin
        r_eject_d <= 1'b1;
      end else if (w_sel_n) begin
        r_eject_n <= 1'b1;
      end else if ((r_state == ST_EJECT) && (w_next != ST_EJECT)) begin
        r_eject_d <= 1'b0;
        r_eject_n <= 1'b0;
      end

      if (r_state == ST_IDLE) begin
        if (load) begin
          r_nickels <= load_n;
          r_dimes   <= load_d;
        end else if (start) begin
          r_remaining <= amount;
          r_short     <= 1'b0;
        end
      end

      if (w_short_sel) r_short <= 1'b1;

      // SELECT only picks a coin that is in stock and not more than owed,
      // so these subtractions cannot wrap.
      if (w_coin_taken) begin
        if (r_eject_d) begin
          if (r_dimes != '0) r_dimes <= r_dimes - CNT_W'(1);
          r_remaining <= r_remaining - AMT_W'(DIME);
        end else begin
          if (r_nickels != '0) r_nickels <= r_nickels - CNT_W'(1);
          r_remaining <= r_remaining - AMT_W'(NICKEL);
        end
      end
    end
  end

  assign eject_n   = r_eject_n;
  assign eject_d   = r_eject_d;
  assign busy      = r_busy;
  assign done      = r_done;
  assign short     = r_short;
  assign fault     = r_fault;
  assign remaining = r_remaining;
  assign nickels   = r_nickels;
  assign dimes     = r_dimes;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Dispenses change after a sale: pays out a requested amount, in nickel units, as dime and nickel eject requests to the coin-return mechanism.
- Tracks on-board coin inventory and flags when it cannot pay exactly.
- Sits downstream of the sale controller (which computes overpayment) and drives the coin-return solenoid interface through a 4-phase req/ack handshake.

Parameters:
AMT_W, 4, width of amount/remaining in nickel units (max 15 = 75c)
CNT_W, 6, width of each coin inventory counter
TIMEOUT, 255, max cycles to wait for coin_ack rise or fall before fault

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to dispense amount; sampled only in IDLE
amount  input  AMT_W  change to pay, nickel units
load  input  1  load inventory; sampled only in IDLE
load_n  input  CNT_W  nickel count to load
load_d  input  CNT_W  dime count to load
coin_ack  input  1  mechanism ack: high = coin released, low = ready
eject_n  output  1  nickel eject request (held until ack)
eject_d  output  1  dime eject request (held until ack)
busy  output  1  high in every state except IDLE and FAULT
done  output  1  one-cycle pulse at completion (exact or short)
short  output  1  last transaction could not be paid exactly; held until next accepted start
fault  output  1  sticky handshake timeout; cleared only by reset
remaining  output  AMT_W  unpaid amount (nickel units)
nickels  output  CNT_W  current nickel inventory
dimes  output  CNT_W  current dime inventory

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; inventory 0; timeout counter 0. Asserting reset mid-eject drops eject_n/eject_d immediately.
- All outputs are registered.
- States: IDLE, SELECT, EJECT, RELEASE, DONE, FAULT.
- IDLE:
  - load=1: nickels<=load_n, dimes<=load_d.
  - load=1 and start=1 in the same cycle: load wins, start is ignored.
  - start=1 (load=0): remaining<=amount, short<=0, go to SELECT.
  - start and load are ignored in all other states.
- SELECT (1 cycle); first matching rule applies:
  - remaining>=2 and dimes>0: go to EJECT, eject_d=1.
  - else remaining>=1 and nickels>0: go to EJECT, eject_n=1.
  - else remaining==0: go to DONE.
  - else: go to DONE with short<=1.
  - Never overpay: remaining odd with only dimes left ends short.
- Eject request timing: rises in the cycle after SELECT. Exactly one of eject_n/eject_d is high at a time.
- EJECT: hold the request until coin_ack=1. On that edge:
  - drop the request;
  - decrement the matching inventory;
  - remaining -= 2 for a dime, 1 for a nickel;
  - go to RELEASE.
- RELEASE: wait for coin_ack=0, then go to SELECT. Back-to-back coins are spaced by at least 1 SELECT cycle.
- Timeout:
  - Counter clears on entry to EJECT and to RELEASE.
  - Counter reaching TIMEOUT without the awaited coin_ack level: go to FAULT.
  - FAULT: eject low, busy low, fault=1, remaining and inventory frozen; exited only by reset.
- DONE: done=1 for exactly 1 cycle, then IDLE.
  - amount=0: start -> SELECT -> DONE, so done is high 2 cycles after the start edge.
- coin_ack high while no request is pending (IDLE/SELECT): ignored; it only matters in EJECT and RELEASE.
- Inventory never underflows (decrement only on a selected coin with count>0). Load saturation is not needed (load overwrites).

Decomposition:
- Shared package: state enum encoding, coin-value constants (NICKEL=1, DIME=2 in nickel units), and AMT_W/CNT_W defaults, shared with the sale controller.
- Natural sub-module: handshake_timer (clearable counter with a terminal-count flag). It is instantiated once and cleared on EJECT/RELEASE entry.

Test Plan:
- Load n=5,d=5; start amount=3; ack each request after 2 cycles -> eject_d then eject_n; done pulse; short=0; remaining=0; nickels=4, dimes=4.
- Load n=2,d=0; start amount=4 -> two nickel ejects; done; short=1; remaining=2; nickels=0.
- Load n=0,d=3; start amount=1 -> no eject; done 2 cycles after start; short=1; remaining=1; dimes=3.
- Start amount=2 and never raise coin_ack -> eject_d held TIMEOUT cycles, then fault=1, eject_d=0, busy=0. A later start is ignored until reset.
- Start and load in the same IDLE cycle -> inventory loaded, busy stays 0. A start pulse while busy does not change remaining.
- Assert reset while eject_n=1 -> eject_n=0, state IDLE and inventory 0 without waiting for a clock edge.
